// File: rtl/des_key_sched_seq_pkg.sv
// Shared DES key-schedule constants, PC-1/PC-2 tables and FSM state encoding.
// Used by des_key_step and des_key_sched_seq (optional DES_KEY_PARITY_CHECK_EN lives in the top).
package des_key_sched_seq_pkg;

   localparam int DES_KEY_W  = 64;
   localparam int DES_CD_W   = 28;
   localparam int DES_RK_W   = 48;
   localparam int DES_ROUNDS = 16;

   // Bit r-1 set means round r rotates by one instead of two (rounds 1, 2, 9, 16).
   localparam logic [15:0] SHIFT_SCHED = 16'h8103;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_GEN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Standard tables: entries are 1-based bit positions counted from the MSB.
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) cd[55-i] = key[6'(64 - PC1_TAB[i])];
      return cd;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] rk;
      rk = '0;
      for (int i = 0; i < 48; i++) rk[47-i] = cd[6'(56 - PC2_TAB[i])];
      return rk;
   endfunction

endpackage

// File: rtl/des_key_sched_seq_step.sv
// One combinational DES key-schedule round: rotate C/D left by 1 or 2, then PC-2.
module des_key_step
   import des_key_sched_seq_pkg::*;
(
   input  logic [DES_CD_W-1:0] c_in,
   input  logic [DES_CD_W-1:0] d_in,
   input  logic                single_shift,
   output logic [DES_CD_W-1:0] c_out,
   output logic [DES_CD_W-1:0] d_out,
   output logic [DES_RK_W-1:0] round_key
);

   assign c_out = single_shift ? {c_in[26:0], c_in[27]} : {c_in[25:0], c_in[27:26]};
   assign d_out = single_shift ? {d_in[26:0], d_in[27]} : {d_in[25:0], d_in[27:26]};

   assign round_key = pc2({c_out, d_out});

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES / TDES-EDE key scheduler, ROUNDS_PER_CYCLE chained rounds per clock.
// Define DES_KEY_PARITY_CHECK_EN to check odd key-byte parity and zero the table on error.
module des_key_sched_seq
   import des_key_sched_seq_pkg::*;
#(
   parameter int NUM_KEYS         = 1,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [64*NUM_KEYS-1:0]    init_key,
   input  logic                      encrypt_decrypt,
   output logic                      valid_o,
   output logic [768*NUM_KEYS-1:0]   round_keys,
   output logic                      busy_o,
   output logic                      parity_err_o,
   output logic [1:0]                state_o
);

   localparam int KEY_TOT = DES_KEY_W * NUM_KEYS;
   localparam int STAGE_W = DES_RK_W * DES_ROUNDS;
   localparam int TAB_W   = STAGE_W * NUM_KEYS;
   localparam int RPC     = ROUNDS_PER_CYCLE;

   if (!(NUM_KEYS == 1 || NUM_KEYS == 3)) begin : g_bad_num_keys
      $error("des_key_sched_seq: NUM_KEYS must be 1 or 3");
   end
   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
      $error("des_key_sched_seq: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   state_t                 state;
   logic [1:0]             key_idx;
   logic [3:0]             rnd;
   logic [KEY_TOT-1:0]     key_lat;
   logic                   ed_lat;
   logic [DES_CD_W-1:0]    c_q, d_q;
   logic [TAB_W-1:0]       rk_work, rk_next;

   logic [1:0]             key_sel;
   logic                   stage_dir;
   logic [DES_KEY_W-1:0]   cur_key;
   logic [55:0]            cd_load;
   logic                   par_bad;

   // Stage k is always computed k-th; only the key chosen and its slot direction vary.
   always_comb begin
      key_sel   = ed_lat ? key_idx : 2'(NUM_KEYS - 1) - key_idx;
      stage_dir = ed_lat ^ (key_idx == 2'd1);
      cur_key   = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         if (key_sel == 2'(i)) cur_key = key_lat[KEY_TOT-1-DES_KEY_W*i -: DES_KEY_W];
      cd_load = pc1(cur_key);
   end

   logic [DES_CD_W-1:0] c_ch [RPC+1];
   logic [DES_CD_W-1:0] d_ch [RPC+1];
   logic [DES_RK_W-1:0] step_key  [RPC];
   logic [3:0]          step_slot [RPC];

   assign c_ch[0] = c_q;
   assign d_ch[0] = d_q;

   for (genvar g = 0; g < RPC; g++) begin : g_step
      logic [3:0] rnd_g;
      assign rnd_g = rnd + 4'(g);
      des_key_step u_step (
         .c_in         (c_ch[g]),
         .d_in         (d_ch[g]),
         .single_shift (SHIFT_SCHED[rnd_g]),
         .c_out        (c_ch[g+1]),
         .d_out        (d_ch[g+1]),
         .round_key    (step_key[g])
      );
      assign step_slot[g] = stage_dir ? rnd_g : 4'd15 - rnd_g;
   end

   always_comb begin
      rk_next = rk_work;
      if (state == ST_GEN)
         for (int g = 0; g < RPC; g++)
            for (int st = 0; st < NUM_KEYS; st++)
               for (int sl = 0; sl < DES_ROUNDS; sl++)
                  if (key_idx == 2'(st) && step_slot[g] == 4'(sl))
                     rk_next[TAB_W-1-STAGE_W*st-DES_RK_W*sl -: DES_RK_W] = step_key[g];
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   always_comb begin
      par_bad = 1'b0;
      for (int b = 0; b < 8*NUM_KEYS; b++)
         if (!(^init_key[8*b +: 8])) par_bad = 1'b1;
   end
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         ready_o      <= 1'b1;
         valid_o      <= 1'b0;
         busy_o       <= 1'b0;
         parity_err_o <= 1'b0;
         round_keys   <= '0;
         rk_work      <= '0;
         key_lat      <= '0;
         ed_lat       <= 1'b0;
         c_q          <= '0;
         d_q          <= '0;
         rnd          <= '0;
         key_idx      <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (valid_i && ready_o) begin
                  key_lat      <= init_key;
                  ed_lat       <= encrypt_decrypt;
                  key_idx      <= '0;
                  state        <= ST_LOAD;
                  ready_o      <= 1'b0;
                  valid_o      <= 1'b0;
                  busy_o       <= 1'b1;
                  parity_err_o <= par_bad;
               end
            end
            ST_LOAD: begin
               {c_q, d_q} <= cd_load;
               rnd        <= '0;
               state      <= ST_GEN;
            end
            ST_GEN: begin
               c_q     <= c_ch[RPC];
               d_q     <= d_ch[RPC];
               rk_work <= rk_next;
               rnd     <= rnd + 4'(RPC);
               if (rnd == 4'(DES_ROUNDS - RPC)) begin
                  if (key_idx == 2'(NUM_KEYS - 1)) begin
                     state      <= ST_DONE;
                     valid_o    <= 1'b1;
                     ready_o    <= 1'b1;
                     busy_o     <= 1'b0;
                     round_keys <= parity_err_o ? '0 : rk_next;
                  end else begin
                     key_idx <= key_idx + 2'd1;
                     state   <= ST_LOAD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench: five single-DES schedulers (1/2/4/8/16 rounds per clock) plus one TDES/16 instance.
// Expected round keys are the textbook values for key 0x133457799BBCDFF1.
module tb_des_key_sched_seq;

   localparam logic [63:0]  K_GOOD  = 64'h133457799BBCDFF1;
   localparam logic [63:0]  K_BADP  = 64'h133457799BBCDFF0;
   localparam logic [63:0]  K_ZERO  = 64'h0101010101010101;
   localparam logic [63:0]  K_ONES  = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [47:0]  RK1     = 48'h1B02EFFC7072;
   localparam logic [47:0]  RK2     = 48'h79AED9DBC9E5;
   localparam logic [47:0]  RK16    = 48'hCB3D8B0E17F5;
   localparam int           EXP_LAT [6] = '{17, 9, 5, 3, 2, 6};

   logic          clk;
   logic          rst;
   logic          valid_i;
   logic          ed;
   logic [63:0]   key1;
   logic [191:0]  key3;

   logic          ready_s [5];
   logic          valid_s [5];
   logic          busy_s  [5];
   logic          perr_s  [5];
   logic [1:0]    state_s [5];
   logic [767:0]  rk_s    [5];

   logic          ready_t, valid_t, busy_t, perr_t;
   logic [1:0]    state_t_dbg;
   logic [2303:0] rk_t;

   int n_tests = 0;
   int n_fail  = 0;
   int lat [6];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   // ---------------- DUTs ----------------
   for (genvar g = 0; g < 5; g++) begin : g_des
      des_key_sched_seq #(.NUM_KEYS(1), .ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .clk             (clk),
         .rst             (rst),
         .valid_i         (valid_i),
         .ready_o         (ready_s[g]),
         .init_key        (key1),
         .encrypt_decrypt (ed),
         .valid_o         (valid_s[g]),
         .round_keys      (rk_s[g]),
         .busy_o          (busy_s[g]),
         .parity_err_o    (perr_s[g]),
         .state_o         (state_s[g])
      );
   end

   des_key_sched_seq #(.NUM_KEYS(3), .ROUNDS_PER_CYCLE(16)) u_tdes (
      .clk             (clk),
      .rst             (rst),
      .valid_i         (valid_i),
      .ready_o         (ready_t),
      .init_key        (key3),
      .encrypt_decrypt (ed),
      .valid_o         (valid_t),
      .round_keys      (rk_t),
      .busy_o          (busy_t),
      .parity_err_o    (perr_t),
      .state_o         (state_t_dbg)
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Pulses valid_i for one clock; returns #1 after the accept edge.
   task automatic send_req(input logic [63:0] k1, input logic [191:0] k3, input logic e);
      key1    = k1;
      key3    = k3;
      ed      = e;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   // Runs a fixed number of cycles and records the first cycle each DUT shows valid_o.
   task automatic wait_all(input int cycles);
      for (int i = 0; i < 6; i++) lat[i] = -1;
      for (int c = 1; c <= cycles; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 5; i++)
            if (lat[i] < 0 && valid_s[i]) lat[i] = c;
         if (lat[5] < 0 && valid_t) lat[5] = c;
      end
   endtask

   task automatic check_des_keys(input string tag, input logic [47:0] top,
                                 input logic [47:0] second, input logic [47:0] bottom,
                                 input logic second_at_top);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("%s_r%0d_top", tag, 1 << i), 64'(rk_s[i][767:720]), 64'(top));
         check_eq($sformatf("%s_r%0d_bot", tag, 1 << i), 64'(rk_s[i][47:0]), 64'(bottom));
         if (second_at_top)
            check_eq($sformatf("%s_r%0d_k2", tag, 1 << i), 64'(rk_s[i][719:672]), 64'(second));
         else
            check_eq($sformatf("%s_r%0d_k2", tag, 1 << i), 64'(rk_s[i][95:48]), 64'(second));
      end
   endtask

   task automatic check_latencies(input string tag);
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("%s_lat%0d", tag, i), 64'(lat[i]), 64'(EXP_LAT[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b1;
      valid_i = 1'b0;
      ed      = 1'b1;
      key1    = '0;
      key3    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check_eq("rst_ready", 64'(ready_s[0]), 64'd1);
      check_eq("rst_valid", 64'(valid_s[0]), 64'd0);
      check_eq("rst_busy", 64'(busy_s[0]), 64'd0);
      check_eq("rst_perr", 64'(perr_s[0]), 64'd0);
      check_eq("rst_state", 64'(state_s[0]), 64'd0);
      check_eq("rst_keys_zero", 64'(|rk_s[0]), 64'd0);
      check_eq("rst_tdes_ready", 64'(ready_t), 64'd1);

      // DES encrypt on every width, TDES encrypt with K1=known, K2=zero-key, K3=ones-key
      send_req(K_GOOD, {K_GOOD, K_ZERO, K_ONES}, 1'b1);
      wait_all(20);
      check_latencies("enc");
      check_des_keys("enc", RK1, RK2, RK16, 1'b1);
      check_eq("t_enc_s0_top", 64'(rk_t[2303:2256]), 64'(RK1));
      check_eq("t_enc_s0_bot", 64'(rk_t[1583:1536]), 64'(RK16));
      check_eq("t_enc_s1_zero", 64'(|rk_t[1535:768]), 64'd0);
      check_eq("t_enc_s2_ones", 64'(&rk_t[767:0]), 64'd1);
      check_eq("done_state", 64'(state_s[0]), 64'd3);

      // Decrypt: reversed table; valid_o drops right after accept
      send_req(K_GOOD, {K_GOOD, K_ZERO, K_ONES}, 1'b0);
      check_eq("acc_valid_drop", 64'(valid_s[0]), 64'd0);
      check_eq("acc_busy", 64'(busy_s[0]), 64'd1);
      check_eq("acc_ready", 64'(ready_s[0]), 64'd0);
      wait_all(20);
      check_latencies("dec");
      check_des_keys("dec", RK16, RK2, RK1, 1'b0);
      check_eq("t_dec_s0_ones", 64'(&rk_t[2303:1536]), 64'd1);
      check_eq("t_dec_s1_zero", 64'(|rk_t[1535:768]), 64'd0);
      check_eq("t_dec_s2_top", 64'(rk_t[767:720]), 64'(RK16));
      check_eq("t_dec_s2_bot", 64'(rk_t[47:0]), 64'(RK1));
      check_eq("hold_valid", 64'(valid_s[0]), 64'd1);

      // Requests during GEN are ignored and the old table holds until DONE
      send_req(K_GOOD, {K_GOOD, K_ZERO, K_ONES}, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      key1    = K_ZERO;
      ed      = 1'b0;
      valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("busy_ready_%0d", c), 64'(ready_s[0]), 64'd0);
      end
      check_eq("busy_old_keys", 64'(rk_s[0][767:720]), 64'(RK16));
      check_eq("busy_valid_low", 64'(valid_s[0]), 64'd0);
      valid_i = 1'b0;
      begin
         int c;
         c = 0;
         while (!valid_s[0] && c < 40) begin
            @(posedge clk);
            #1;
            c++;
         end
      end
      check_eq("busy_done_valid", 64'(valid_s[0]), 64'd1);
      check_eq("busy_new_top", 64'(rk_s[0][767:720]), 64'(RK1));
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of GEN discards the request
      send_req(K_GOOD, {K_GOOD, K_ZERO, K_ONES}, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("mid_rst_valid", 64'(valid_s[0]), 64'd0);
      check_eq("mid_rst_keys", 64'(|rk_s[0]), 64'd0);
      check_eq("mid_rst_ready", 64'(ready_s[0]), 64'd1);
      check_eq("mid_rst_busy", 64'(busy_s[0]), 64'd0);
      check_eq("mid_rst_t_keys", 64'(|rk_t), 64'd0);
      wait_all(20);
      check_eq("mid_rst_no_valid", 64'(lat[0]), -64'sd1);

      // Key with a bad parity byte
      send_req(K_BADP, {K_GOOD, K_ZERO, K_ONES}, 1'b1);
      wait_all(20);
      check_eq("par_valid", 64'(valid_s[0]), 64'd1);
      check_eq("par_lat", 64'(lat[0]), 64'd17);
`ifdef DES_KEY_PARITY_CHECK_EN
      check_eq("par_err", 64'(perr_s[0]), 64'd1);
      check_eq("par_keys_zero", 64'(|rk_s[0]), 64'd0);
      send_req(K_GOOD, {K_GOOD, K_ZERO, K_ONES}, 1'b1);
      check_eq("par_clear", 64'(perr_s[0]), 64'd0);
      wait_all(20);
      check_eq("par_good_top", 64'(rk_s[0][767:720]), 64'(RK1));
`else
      check_eq("par_err_tied", 64'(perr_s[0]), 64'd0);
      check_eq("par_ignored_top", 64'(rk_s[0][767:720]), 64'(RK1));
      check_eq("par_ignored_bot", 64'(rk_s[0][47:0]), 64'(RK16));
`endif
      check_eq("par_tdes_ok", 64'(perr_t), 64'd0);

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
